// File: rtl/train_ctrl_pkg.sv
// Shared train-controller constants: timer FSM encodings, bus widths, timed state codes.
// Pure declarations; no logic.
package train_ctrl_pkg;

  localparam int TIME_W  = 19;
  localparam int STATE_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Controller states that carry a dwell time from Parameters
  localparam logic [STATE_W-1:0] CTRL_ST_TIMED_A = 4'b0011;
  localparam logic [STATE_W-1:0] CTRL_ST_TIMED_B = 4'b0100;
  localparam logic [STATE_W-1:0] CTRL_ST_TIMED_C = 4'b0101;

endpackage

// File: rtl/state_timer_ms_prescaler.sv
// Millisecond prescaler: counts clk cycles while enabled, strobes o_tick on terminal count.
// o_tick is combinational from the registered count; i_clr restarts the count synchronously.
module ms_prescaler #(
  parameter int CLK_PER_MS = 50000,
  parameter int PS_W       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam logic [PS_W-1:0] TC = PS_W'(CLK_PER_MS - 1);

  logic [PS_W-1:0] r_cnt;
  logic            w_tc;

  assign w_tc   = (r_cnt == TC);
  assign o_tick = i_en && !i_clr && w_tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_tc) r_cnt <= '0;
      else      r_cnt <= r_cnt + PS_W'(1);
    end
  end

endmodule

// File: rtl/state_timer.sv
// Dwell timer: reloads on every present_state change, counts t ms down, pulses timeout once.
// timeout rises exactly t*CLK_PER_MS cycles after the load edge.
module state_timer
  import train_ctrl_pkg::*;
#(
  parameter int CLK_PER_MS = 50000,
  parameter int PS_W       = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STATE_W-1:0] present_state,
  input  logic [TIME_W-1:0]  t,
  output logic               timeout,
  output logic               busy,
  output logic               expired,
  output logic [TIME_W-1:0]  remaining
);

  logic [1:0]         r_state;
  logic [STATE_W-1:0] r_prev;
  logic [TIME_W-1:0]  r_remaining;
  logic               r_timeout;
  logic               w_chg;
  logic               w_run;
  logic               w_tick;

  assign w_chg = (present_state != r_prev);
  assign w_run = (r_state == ST_RUN);

  ms_prescaler #(
    .CLK_PER_MS (CLK_PER_MS),
    .PS_W       (PS_W)
  ) u_ms_prescaler (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_chg),
    .i_en   (w_run),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_prev      <= '0;
      r_remaining <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_prev    <= present_state;
      r_timeout <= 1'b0;
      // A state change always reloads, even on the edge the old dwell would have expired
      if (w_chg) begin
        if (t != '0) begin
          r_remaining <= t;
          r_state     <= ST_RUN;
        end else begin
          r_remaining <= '0;
          r_state     <= ST_IDLE;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            if (w_tick) begin
              if (r_remaining == TIME_W'(1)) begin
                r_remaining <= '0;
                r_state     <= ST_DONE;
                r_timeout   <= 1'b1;
              end else if (r_remaining != '0) begin
                r_remaining <= r_remaining - TIME_W'(1);
              end
            end
          end
          ST_DONE: r_remaining <= '0;
          ST_IDLE: ;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign timeout   = r_timeout;
  assign busy      = (r_state == ST_RUN);
  assign expired   = (r_state == ST_DONE);
  assign remaining = r_remaining;

endmodule
